// File: rtl/clusterop_pkg.sv
// Shared constants for the clusterOp distance/argmin stage: widths, FSM encoding
// and the accumulator saturation limits.
package clusterop_pkg;

    localparam int PROD_WIDTH   = 13;
    localparam int ACC_WIDTH    = 15;
    localparam int DIM          = 4;
    localparam int NUM_CLUSTERS = 8;
    localparam int IDX_WIDTH    = 3;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/clusterop_dist_argmin_if.sv
// Product-beat input stream and result output stream of the distance/argmin stage.
// master = producer/consumer side, slave = the argmin block.
interface clusterop_dist_argmin_if #(
    parameter int PROD_WIDTH = clusterop_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH  = clusterop_pkg::ACC_WIDTH,
    parameter int IDX_WIDTH  = clusterop_pkg::IDX_WIDTH
);
    logic                         prod_valid;
    logic signed [PROD_WIDTH-1:0] prod_data;
    logic                         prod_last_dim;
    logic                         prod_last_clus;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_WIDTH-1:0]         out_idx;
    logic signed [ACC_WIDTH-1:0]  out_dist;

    modport master (
        output prod_valid, prod_data, prod_last_dim, prod_last_clus, out_ready,
        input  in_ready, out_valid, out_idx, out_dist
    );

    modport slave (
        input  prod_valid, prod_data, prod_last_dim, prod_last_clus, out_ready,
        output in_ready, out_valid, out_idx, out_dist
    );
endinterface

// File: rtl/clusterop_sat_add.sv
// Combinational signed add of a product onto the accumulator, clamped to the
// accumulator's signed range instead of wrapping.
module clusterop_sat_add #(
    parameter int PROD_WIDTH = clusterop_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH  = clusterop_pkg::ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [PROD_WIDTH-1:0] prod,
    output logic signed [ACC_WIDTH-1:0]  sum
);
    localparam logic signed [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] wide;

    // One guard bit suffices because a product never exceeds the accumulator range.
    always_comb begin
        wide = {acc[ACC_WIDTH-1], acc}
             + {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            sum = wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX;
        end else begin
            sum = wide[ACC_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/clusterop_dist_argmin.sv
// Accumulates DIM products per candidate cluster and reports the index and
// distance of the nearest cluster once per point, held until downstream accepts.
module clusterop_dist_argmin #(
    parameter int PROD_WIDTH   = clusterop_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH    = clusterop_pkg::ACC_WIDTH,
    parameter int DIM          = clusterop_pkg::DIM,
    parameter int NUM_CLUSTERS = clusterop_pkg::NUM_CLUSTERS,
    parameter int IDX_WIDTH    = clusterop_pkg::IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    clusterop_dist_argmin_if.slave       bus,
    output logic                         err
);
    import clusterop_pkg::*;

    localparam int DIM_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [DIM_W-1:0]     DIM_LAST  = DIM_W'(DIM - 1);
    localparam logic [IDX_WIDTH-1:0] CLUS_LAST = IDX_WIDTH'(NUM_CLUSTERS - 1);

    logic                        state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] min_dist;
    logic [IDX_WIDTH-1:0]        min_idx;
    logic [DIM_W-1:0]            dim_cnt;
    logic [IDX_WIDTH-1:0]        clus_cnt;
    logic                        out_valid_q;
    logic [IDX_WIDTH-1:0]        out_idx_q;
    logic signed [ACC_WIDTH-1:0] out_dist_q;
    logic                        err_q;

    logic signed [ACC_WIDTH-1:0] sum;
    logic                        beat_acc;
    logic                        last_pos;
    logic                        point_end;
    logic                        take_min;
    logic                        frame_err;
    logic signed [ACC_WIDTH-1:0] next_min;
    logic [IDX_WIDTH-1:0]        next_idx;

    clusterop_sat_add #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
        .acc  (acc),
        .prod (bus.prod_data),
        .sum  (sum)
    );

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_dist  = out_dist_q;
    assign err           = err_q;

    assign beat_acc  = bus.prod_valid && (state == ST_ACCUM);
    assign last_pos  = (clus_cnt == CLUS_LAST);
    assign point_end = bus.prod_last_dim && (bus.prod_last_clus || last_pos);
    // The first cluster of a point always seeds the minimum; ties keep the older index.
    assign take_min  = (clus_cnt == '0) || (sum < min_dist);
    assign next_min  = take_min ? sum : min_dist;
    assign next_idx  = take_min ? clus_cnt : min_idx;
    assign frame_err = (bus.prod_last_dim && (dim_cnt != DIM_LAST))
                    || ((dim_cnt == DIM_LAST) && !bus.prod_last_dim)
                    || (bus.prod_last_dim && (bus.prod_last_clus != last_pos));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            min_dist    <= '0;
            min_idx     <= '0;
            dim_cnt     <= '0;
            clus_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_dist_q  <= '0;
            err_q       <= 1'b0;
        end else if (ce) begin
            if (state == ST_ACCUM) begin
                if (beat_acc) begin
                    if (frame_err) begin
                        err_q <= 1'b1;
                    end
                    if (bus.prod_last_dim) begin
                        acc      <= '0;
                        dim_cnt  <= '0;
                        min_dist <= next_min;
                        min_idx  <= next_idx;
                        if (point_end) begin
                            out_dist_q  <= next_min;
                            out_idx_q   <= next_idx;
                            out_valid_q <= 1'b1;
                            clus_cnt    <= '0;
                            state       <= ST_HOLD;
                        end else begin
                            clus_cnt <= clus_cnt + IDX_WIDTH'(1);
                        end
                    end else begin
                        acc     <= sum;
                        dim_cnt <= (dim_cnt == DIM_LAST) ? '0 : dim_cnt + DIM_W'(1);
                    end
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                state       <= ST_ACCUM;
            end
        end
    end
endmodule

// File: tb/tb_clusterop_dist_argmin.sv
// Bench for clusterop_dist_argmin: a 15-bit and a 14-bit accumulator instance driven
// with identical beats and checked against tables and a per-point argmin model.
module tb_clusterop_dist_argmin;

    localparam int DIM  = 4;
    localparam int NCL  = 8;

    typedef logic [3:0][12:0] beats4_t;

    typedef struct {
        beats4_t vf;
        int      ia;
        beats4_t va;
        int      ib;
        beats4_t vb;
        int      exp_idx;
        int      exp_d15;
        int      exp_d14;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic err15, err14;

    int total = 0;
    int bad   = 0;

    int ce_mode  = 0;
    int rdy_mode = 0;

    int m_part[2];
    int m_sums[2][NCL];
    int m_ncl;
    int m_dpos;
    bit m_err;
    int m_idx[2];
    int m_dist[2];

    vec_t vecs[6];

    clusterop_dist_argmin_if                   if15 ();
    clusterop_dist_argmin_if #(.ACC_WIDTH(14)) if14 ();

    clusterop_dist_argmin dut15 (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (if15.slave),
        .err   (err15)
    );

    clusterop_dist_argmin #(.ACC_WIDTH(14)) dut14 (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (if14.slave),
        .err   (err14)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic beats4_t mk4(input int a0, input int a1, input int a2, input int a3);
        beats4_t r;
        r[0] = 13'(a0);
        r[1] = 13'(a1);
        r[2] = 13'(a2);
        r[3] = 13'(a3);
        return r;
    endfunction

    function automatic int clampw(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        m_part[0] = 0;
        m_part[1] = 0;
        m_ncl     = 0;
        m_dpos    = 0;
        m_err     = 0;
    endtask

    // Reference: running clamped partial sums, a list of cluster totals, argmin at point end.
    task automatic model_beat(input int d, input bit ld, input bit lc, output bit ended);
        ended = 0;
        for (int w = 0; w < 2; w++) m_part[w] = clampw(m_part[w] + d, (w == 0) ? 15 : 14);
        if (ld && m_dpos != DIM - 1) m_err = 1;
        if (!ld && m_dpos == DIM - 1) m_err = 1;
        if (ld && (lc != (m_ncl == NCL - 1))) m_err = 1;
        if (ld) begin
            for (int w = 0; w < 2; w++) begin
                m_sums[w][m_ncl] = m_part[w];
                m_part[w] = 0;
            end
            m_ncl++;
            m_dpos = 0;
            if (lc || m_ncl == NCL) begin
                for (int w = 0; w < 2; w++) begin
                    int best;
                    best = 0;
                    for (int i = 1; i < m_ncl; i++)
                        if (m_sums[w][i] < m_sums[w][best]) best = i;
                    m_idx[w]  = best;
                    m_dist[w] = m_sums[w][best];
                end
                m_ncl = 0;
                ended = 1;
            end
        end else begin
            m_dpos = (m_dpos == DIM - 1) ? 0 : m_dpos + 1;
        end
    endtask

    task automatic drive_beat(input bit v, input int d, input bit ld, input bit lc);
        if15.prod_valid = v;     if14.prod_valid = v;
        if15.prod_data = 13'(d); if14.prod_data = 13'(d);
        if15.prod_last_dim = ld; if14.prod_last_dim = ld;
        if15.prod_last_clus = lc; if14.prod_last_clus = lc;
    endtask

    task automatic set_ready(input bit r);
        if15.out_ready = r;
        if14.out_ready = r;
    endtask

    task automatic tick_controls();
        case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = ~ce;
            default: ce = 1'($urandom_range(1));
        endcase
        case (rdy_mode)
            0:       set_ready(1'b1);
            1:       set_ready(1'b0);
            default: set_ready(1'($urandom_range(1)));
        endcase
    endtask

    task automatic check_output();
        check("out_valid15", int'(if15.out_valid), 1);
        check("out_valid14", int'(if14.out_valid), 1);
        check("out_idx15", int'(if15.out_idx), m_idx[0]);
        check("out_idx14", int'(if14.out_idx), m_idx[1]);
        check("out_dist15", int'($signed(if15.out_dist)), m_dist[0]);
        check("out_dist14", int'($signed(if14.out_dist)), m_dist[1]);
        check("err15", int'(err15), int'(m_err));
        check("err14", int'(err14), int'(m_err));
    endtask

    // One beat: present it until the DUT takes it, then advance the model.
    task automatic apply_stimulus(input int d, input bit ld, input bit lc, output bit ended);
        bit done;
        done  = 0;
        ended = 0;
        drive_beat(1'b1, d, ld, lc);
        for (int k = 0; k < 200 && !done; k++) begin
            tick_controls();
            done = ce && if15.in_ready;
            @(posedge clk);
            #1;
        end
        drive_beat(1'b0, 0, 1'b0, 1'b0);
        if (!done) begin
            check("accept_timeout", 0, 1);
        end else begin
            model_beat(d, ld, lc, ended);
            if (ended) check_output();
            else check("out_valid_mid", int'(if15.out_valid), 0);
        end
    endtask

    function automatic int vec_beat(input vec_t v, input int c, input int d);
        if (c == v.ia) return int'($signed(v.va[d]));
        if (c == v.ib) return int'($signed(v.vb[d]));
        return int'($signed(v.vf[d]));
    endfunction

    task automatic send_vec(input vec_t v, input int id);
        bit ended;
        ended = 0;
        for (int c = 0; c < NCL; c++)
            for (int d = 0; d < DIM; d++)
                apply_stimulus(vec_beat(v, c, d), d == DIM - 1, (d == DIM - 1) && (c == NCL - 1), ended);
        check($sformatf("vec%0d_ended", id), int'(ended), 1);
        check($sformatf("vec%0d_idx15", id), int'(if15.out_idx), v.exp_idx);
        check($sformatf("vec%0d_idx14", id), int'(if14.out_idx), v.exp_idx);
        check($sformatf("vec%0d_dist15", id), int'($signed(if15.out_dist)), v.exp_d15);
        check($sformatf("vec%0d_dist14", id), int'($signed(if14.out_dist)), v.exp_d14);
    endtask

    task automatic drain();
        ce = 1'b1;
        set_ready(1'b1);
        for (int k = 0; k < 20 && if15.out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain", int'(if15.out_valid), 0);
    endtask

    task automatic do_reset(input bit ce_val);
        reset = 1'b1;
        ce    = ce_val;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, int'(if15.out_valid | if14.out_valid), 0);
        check({tag, "_idx"}, int'(if15.out_idx | if14.out_idx), 0);
        check({tag, "_dist15"}, int'($signed(if15.out_dist)), 0);
        check({tag, "_dist14"}, int'($signed(if14.out_dist)), 0);
        check({tag, "_err"}, int'(err15 | err14), 0);
        check({tag, "_in_ready"}, int'(if15.in_ready & if14.in_ready), 1);
    endtask

    initial begin
        bit ended;
        int snap_idx, snap_dist;

        vecs[0] = '{vf: mk4(25, 25, 25, 25), ia: 0, va: mk4(10, 10, 10, 10), ib: 3, vb: mk4(1, 1, 1, 2),
                    exp_idx: 3, exp_d15: 5, exp_d14: 5};
        vecs[1] = '{vf: mk4(2, 2, 2, 3), ia: 2, va: mk4(1, 2, 2, 2), ib: 5, vb: mk4(4, 1, 1, 1),
                    exp_idx: 2, exp_d15: 7, exp_d14: 7};
        vecs[2] = '{vf: mk4(4095, 4095, 4095, 4095), ia: 0, va: mk4(4095, 4095, 4095, 4095),
                    ib: 1, vb: mk4(4095, 4095, 4095, 4095), exp_idx: 0, exp_d15: 16380, exp_d14: 8191};
        vecs[3] = '{vf: mk4(4095, 4095, 4095, 4095), ia: 0, va: mk4(4095, 4095, 4095, 4095),
                    ib: 6, vb: mk4(-4096, -4096, -4096, -4096), exp_idx: 6, exp_d15: -16384, exp_d14: -8192};
        vecs[4] = '{vf: mk4(-100, 50, 3, -1), ia: 7, va: mk4(-50, -50, -50, -50),
                    ib: 0, vb: mk4(-100, 50, 3, -1), exp_idx: 7, exp_d15: -200, exp_d14: -200};
        vecs[5] = '{vf: mk4(4095, 4095, 4095, 4095), ia: 1, va: mk4(4095, 4095, 4095, -4096),
                    ib: 0, vb: mk4(4095, 4095, 4095, 4095), exp_idx: 1, exp_d15: 8189, exp_d14: 4095};

        drive_beat(1'b0, 0, 1'b0, 1'b0);
        set_ready(1'b0);
        ce = 1'b0;
        do_reset(1'b0);
        check_reset_state("reset");

        ce_mode  = 0;
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            send_vec(vecs[i], i);
            drain();
        end

        // Backpressure: result must hold and no new beat may enter.
        rdy_mode = 1;
        send_vec(vecs[0], 10);
        snap_idx  = int'(if15.out_idx);
        snap_dist = int'($signed(if15.out_dist));
        drive_beat(1'b1, 77, 1'b0, 1'b0);
        set_ready(1'b0);
        ce = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", int'(if15.in_ready | if14.in_ready), 0);
            check("bp_valid", int'(if15.out_valid), 1);
            check("bp_idx", int'(if15.out_idx), snap_idx);
            check("bp_dist", int'($signed(if15.out_dist)), snap_dist);
        end
        drive_beat(1'b0, 0, 1'b0, 1'b0);
        rdy_mode = 0;
        send_vec(vecs[1], 11);
        drain();

        // Framing errors: short cluster 0, early end after cluster 4.
        do_reset(1'b1);
        ce_mode = 0;
        apply_stimulus(5, 1'b0, 1'b0, ended);
        apply_stimulus(5, 1'b0, 1'b0, ended);
        apply_stimulus(5, 1'b1, 1'b0, ended);
        check("frame_err15", int'(err15), 1);
        check("frame_err14", int'(err14), 1);
        for (int d = 0; d < DIM; d++) apply_stimulus(9, d == 3, 1'b0, ended);
        for (int d = 0; d < DIM; d++) apply_stimulus(3, d == 3, 1'b0, ended);
        for (int d = 0; d < DIM; d++) apply_stimulus(20, d == 3, 1'b0, ended);
        for (int d = 0; d < DIM; d++) apply_stimulus(2, d == 3, d == 3, ended);
        check("early_end", int'(ended), 1);
        check("early_idx", int'(if15.out_idx), 4);
        check("early_dist", int'($signed(if15.out_dist)), 8);
        drain();
        send_vec(vecs[1], 12);
        drain();
        check("err_sticky", int'(err15 & err14), 1);

        // ce toggling must not change the result; then reset mid-point.
        do_reset(1'b1);
        ce_mode = 1;
        send_vec(vecs[0], 13);
        drain();
        for (int i = 0; i < 10; i++) apply_stimulus(100 + i, (i % 4) == 3, 1'b0, ended);
        do_reset(1'b0);
        check_reset_state("midreset");
        ce_mode = 0;
        send_vec(vecs[1], 14);
        drain();

        // Randomized points with random ce and out_ready against the model.
        ce_mode  = 2;
        rdy_mode = 2;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < NCL; c++)
                for (int d = 0; d < DIM; d++)
                    apply_stimulus(int'($urandom_range(8191)) - 4096, d == DIM - 1,
                                   (d == DIM - 1) && (c == NCL - 1), ended);
            check("rand_ended", int'(ended), 1);
        end
        ce_mode  = 0;
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
